// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array weight path: lane-feeder FSM states,
// default array geometry and the lane-selection helper.
package systolic_pkg;

    localparam int N_MACS_DEF = 4;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        FEED_IDLE = 2'd0,
        FEED_LOAD = 2'd1,
        FEED_DONE = 2'd2
    } feed_state_t;

    // Isolates the lowest set bit; a zero input yields zero.
    function automatic logic [31:0] lowest_onehot(input logic [31:0] v);
        return v & (~v + 32'd1);
    endfunction

endpackage

// File: rtl/weight_fifo.sv
// Synchronous FIFO for weight words. Flush has priority and empties it on the next edge;
// a pushed word reaches the head one cycle later (no bypass path).
module weight_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;

    logic do_push;
    logic do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign rdata   = mem[rd_ptr];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Power-of-two depth lets the pointers wrap by plain overflow.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // Storage carries no reset; contents are only observed behind count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/weight_lane_feeder.sv
// Writes buffered weight words into the MAC lanes enabled by the controller mask,
// lowest lane first, and raises load_done once every enabled lane has been written.
module weight_lane_feeder
    import systolic_pkg::*;
#(
    parameter int N_MACS     = N_MACS_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_MACS-1:0]             weight_ctrl,
    input  logic                          ctrl_busy,
    input  logic                          s_valid,
    input  logic [DATA_W-1:0]             s_data,
    output logic                          s_ready,
    output logic [N_MACS-1:0]             mac_we,
    output logic [DATA_W-1:0]             mac_wdata,
    output logic                          load_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    feed_state_t       state, state_n;
    logic [N_MACS-1:0] active_mask, active_mask_n;
    logic [N_MACS-1:0] pending, pending_n;
    logic [N_MACS-1:0] mac_we_n;
    logic [DATA_W-1:0] mac_wdata_n;
    logic              load_done_n;

    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;
    logic              arm;
    logic              flush;
    logic              push;
    logic              pop;
    logic [31:0]       pending_w;
    logic [31:0]       sel_w;
    logic [N_MACS-1:0] sel;

    // Only a new, non-zero mask under busy starts a load; a repeated mask is ignored.
    assign arm     = ctrl_busy && (weight_ctrl != '0) && (weight_ctrl != active_mask);
    assign flush   = (state == FEED_LOAD) && (!ctrl_busy || arm);
    assign s_ready = !fifo_full && !flush;
    assign push    = s_valid && s_ready;
    assign pop     = (state == FEED_LOAD) && !fifo_empty && (pending != '0) && !flush;

    assign pending_w = 32'(pending);
    assign sel_w     = lowest_onehot(pending_w);
    assign sel       = sel_w[N_MACS-1:0];

    weight_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (s_data),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FEED_IDLE;
            active_mask <= '0;
            pending     <= '0;
            mac_we      <= '0;
            mac_wdata   <= '0;
            load_done   <= 1'b0;
        end else begin
            state       <= state_n;
            active_mask <= active_mask_n;
            pending     <= pending_n;
            mac_we      <= mac_we_n;
            mac_wdata   <= mac_wdata_n;
            load_done   <= load_done_n;
        end
    end

    always_comb begin
        state_n       = state;
        active_mask_n = active_mask;
        pending_n     = pending;
        mac_we_n      = '0;
        mac_wdata_n   = mac_wdata;
        load_done_n   = 1'b0;
        unique case (state)
            FEED_IDLE: begin
                if (arm) begin
                    active_mask_n = weight_ctrl;
                    pending_n     = weight_ctrl;
                    state_n       = FEED_LOAD;
                end
            end
            FEED_LOAD: begin
                if (!ctrl_busy) begin
                    state_n       = FEED_IDLE;
                    active_mask_n = '0;
                    pending_n     = '0;
                end else if (arm) begin
                    // Restart on the new mask; lanes already written are redone only if set again.
                    active_mask_n = weight_ctrl;
                    pending_n     = weight_ctrl;
                end else if (pop) begin
                    mac_we_n    = sel;
                    mac_wdata_n = fifo_head;
                    pending_n   = pending & ~sel;
                end else if (pending == '0) begin
                    state_n     = FEED_DONE;
                    load_done_n = 1'b1;
                end
            end
            FEED_DONE: begin
                if (arm) begin
                    active_mask_n = weight_ctrl;
                    pending_n     = weight_ctrl;
                    state_n       = FEED_LOAD;
                end else if (!ctrl_busy) begin
                    // Forget the mask so the same one can be loaded again later.
                    state_n       = FEED_IDLE;
                    active_mask_n = '0;
                end else begin
                    load_done_n = 1'b1;
                end
            end
            default: begin
                state_n = FEED_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_weight_lane_feeder.sv
// Directed bench for weight_lane_feeder: expected lane writes go into a queue and a
// monitor checks every mac_we pulse against it; timing/level checks are done inline.
module tb_weight_lane_feeder;

    localparam int N_MACS     = 4;
    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int LW         = $clog2(FIFO_DEPTH) + 1;
    localparam int EW         = N_MACS + DATA_W;

    logic              clk;
    logic              rst;
    logic [N_MACS-1:0] weight_ctrl;
    logic              ctrl_busy;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic [N_MACS-1:0] mac_we;
    logic [DATA_W-1:0] mac_wdata;
    logic              load_done;
    logic [LW-1:0]     fifo_level;

    logic [EW-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    weight_lane_feeder #(
        .N_MACS     (N_MACS),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .weight_ctrl (weight_ctrl),
        .ctrl_busy   (ctrl_busy),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .mac_we      (mac_we),
        .mac_wdata   (mac_wdata),
        .load_done   (load_done),
        .fifo_level  (fifo_level)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic expect_write(input logic [N_MACS-1:0] lane, input logic [DATA_W-1:0] d);
        exp_q.push_back({lane, d});
    endtask

    // Holds s_valid until the word is taken; returns on the negedge after the handshake.
    task automatic wait_accept(input string name);
        int t = 0;
        #1;
        while (!s_ready && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!s_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: s_ready never rose (timeout)", name);
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic push_word(input logic [DATA_W-1:0] d);
        s_valid = 1'b1;
        s_data  = d;
        wait_accept("push");
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        while (!load_done && t < 30) begin
            tick();
            t++;
        end
        check(name, 32'(load_done), 32'd1);
    endtask

    task automatic go_idle();
        ctrl_busy   = 1'b0;
        weight_ctrl = '0;
        tick();
        tick();
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst && mac_we != '0) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got we=%b data=%h, no write expected", mac_we, mac_wdata);
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                if ({mac_we, mac_wdata} !== e) begin
                    n_fail++;
                    $display("FAIL lane_write: got we=%b data=%h expected we=%b data=%h",
                             mac_we, mac_wdata, e[EW-1:DATA_W], e[DATA_W-1:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst         = 1'b1;
        weight_ctrl = '0;
        ctrl_busy   = 1'b0;
        s_valid     = 1'b0;
        s_data      = '0;
        tick();
        check("rst_mac_we", 32'(mac_we), 32'd0);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_wdata", 32'(mac_wdata), 32'd0);
        rst = 1'b0;
        tick();
        #1;
        check("rst_s_ready", 32'(s_ready), 32'd1);

        // Basic load: arm and stream together.
        tick();
        expect_write(4'b0001, 8'h11);
        expect_write(4'b0010, 8'h22);
        ctrl_busy   = 1'b1;
        weight_ctrl = 4'b0011;
        push_word(8'h11);
        push_word(8'h22);
        check("basic_we0", 32'(mac_we), 32'b0001);
        check("basic_not_done", 32'(load_done), 32'd0);
        tick();
        check("basic_we1", 32'(mac_we), 32'b0010);
        check("basic_not_done2", 32'(load_done), 32'd0);
        tick();
        check("basic_done_timing", 32'(load_done), 32'd1);
        check("basic_level", 32'(fifo_level), 32'd0);
        go_idle();
        check("idle_done_low", 32'(load_done), 32'd0);

        // Prefetch in IDLE, then arm.
        push_word(8'h0A);
        push_word(8'h0B);
        check("prefetch_level", 32'(fifo_level), 32'd2);
        expect_write(4'b0100, 8'h0A);
        expect_write(4'b1000, 8'h0B);
        ctrl_busy   = 1'b1;
        weight_ctrl = 4'b1100;
        tick();
        check("prefetch_arm_we", 32'(mac_we), 32'd0);
        tick();
        check("prefetch_we2", 32'(mac_we), 32'b0100);
        check("prefetch_level1", 32'(fifo_level), 32'd1);
        tick();
        check("prefetch_we3", 32'(mac_we), 32'b1000);
        tick();
        check("prefetch_done", 32'(load_done), 32'd1);
        check("prefetch_level0", 32'(fifo_level), 32'd0);
        go_idle();

        // Backpressure: fill the FIFO with no mask, fifth word waits for a pop.
        push_word(8'h31);
        push_word(8'h32);
        push_word(8'h33);
        push_word(8'h34);
        #1;
        check("bp_level_full", 32'(fifo_level), 32'd4);
        check("bp_s_ready_low", 32'(s_ready), 32'd0);
        s_valid = 1'b1;
        s_data  = 8'h35;
        tick();
        tick();
        #1;
        check("bp_still_full", 32'(fifo_level), 32'd4);
        check("bp_still_blocked", 32'(s_ready), 32'd0);
        expect_write(4'b0001, 8'h31);
        expect_write(4'b0010, 8'h32);
        expect_write(4'b0100, 8'h33);
        expect_write(4'b1000, 8'h34);
        ctrl_busy   = 1'b1;
        weight_ctrl = 4'b1111;
        wait_accept("bp_word5");
        wait_done("bp_done");
        check("bp_leftover", 32'(fifo_level), 32'd1);

        // Reset mid-load with a word still buffered.
        tick();
        weight_ctrl = 4'b0110;
        tick();
        rst         = 1'b1;
        ctrl_busy   = 1'b0;
        weight_ctrl = '0;
        #1;
        check("midrst_mac_we", 32'(mac_we), 32'd0);
        check("midrst_done", 32'(load_done), 32'd0);
        check("midrst_level", 32'(fifo_level), 32'd0);
        check("midrst_s_ready", 32'(s_ready), 32'd1);
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        check("postrst_no_write", 32'(mac_we), 32'd0);

        // Abort after one write.
        push_word(8'h41);
        push_word(8'h42);
        expect_write(4'b0100, 8'h41);
        ctrl_busy   = 1'b1;
        weight_ctrl = 4'b1100;
        tick();
        tick();
        check("abort_first_we", 32'(mac_we), 32'b0100);
        ctrl_busy = 1'b0;
        #1;
        check("abort_flush_ready", 32'(s_ready), 32'd0);
        tick();
        check("abort_level", 32'(fifo_level), 32'd0);
        check("abort_done", 32'(load_done), 32'd0);
        tick();
        tick();
        check("abort_quiet", 32'(mac_we), 32'd0);
        weight_ctrl = '0;
        push_word(8'h43);
        push_word(8'h44);
        expect_write(4'b0100, 8'h43);
        expect_write(4'b1000, 8'h44);
        ctrl_busy   = 1'b1;
        weight_ctrl = 4'b1100;
        wait_done("abort_reload_done");
        go_idle();

        // Mask change mid-load.
        push_word(8'h51);
        push_word(8'h52);
        expect_write(4'b0001, 8'h51);
        ctrl_busy   = 1'b1;
        weight_ctrl = 4'b0011;
        tick();
        tick();
        check("chg_first_we", 32'(mac_we), 32'b0001);
        weight_ctrl = 4'b1100;
        #1;
        check("chg_flush_ready", 32'(s_ready), 32'd0);
        tick();
        check("chg_flush_we", 32'(mac_we), 32'd0);
        check("chg_flush_level", 32'(fifo_level), 32'd0);
        expect_write(4'b0100, 8'h53);
        expect_write(4'b1000, 8'h54);
        push_word(8'h53);
        push_word(8'h54);
        wait_done("chg_done");
        check("chg_level", 32'(fifo_level), 32'd0);

        // Zero mask under busy holds the current state.
        weight_ctrl = '0;
        tick();
        tick();
        check("zero_mask_hold", 32'(load_done), 32'd1);
        go_idle();

        tick();
        tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
